// File: rtl/out_port_ctrl.sv
// SAP-2 output-port sequencer for the OUT instruction: a parallel latched port
// with strobe/ack handshake (port 3) and a framed LSB-first serial port (port 4).
module out_port_ctrl #(
    parameter logic [7:0]  PORT3_ADDR  = 8'h03,
    parameter logic [7:0]  PORT4_ADDR  = 8'h04,
    parameter int unsigned BIT_DIV     = 4,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic       iClk,
    input  logic       iReset,
    input  logic       iOutReq,
    input  logic [7:0] iPortAddr,
    input  logic [7:0] iData,
    input  logic       iPort3Ack,
    output logic       oBusy,
    output logic [7:0] oPort3Data,
    output logic       oPort3Strobe,
    output logic       oPort4Serial,
    output logic       oPort4Active,
    output logic       oAddrErr,
    output logic       oOverrun,
    output logic       oTimeout
);

    typedef enum logic [2:0] {
        IDLE,
        P3_WAIT,
        P4_START,
        P4_DATA,
        P4_STOP
    } state_e;

    localparam logic [7:0] DIV_LAST = 8'(BIT_DIV - 1);
    localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);

    state_e     state_q, state_d;
    logic [7:0] p3_data_q, p3_data_d;
    logic       strobe_q, strobe_d;
    logic       serial_q, serial_d;
    logic       active_q, active_d;
    logic       busy_q, busy_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] div_q, div_d;
    logic [7:0] tmo_q, tmo_d;
    logic       addr_err_q, addr_err_d;
    logic       overrun_q, overrun_d;
    logic       timeout_q, timeout_d;

    logic div_wrap;
    assign div_wrap = (div_q == DIV_LAST);

    always_comb begin
        // NOTE: every _d gets a default here so no path through the case leaves a latch.
        state_d    = state_q;
        p3_data_d  = p3_data_q;
        strobe_d   = strobe_q;
        serial_d   = serial_q;
        active_d   = active_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        div_d      = div_q;
        tmo_d      = tmo_q;
        addr_err_d = 1'b0;
        overrun_d  = 1'b0;
        timeout_d  = 1'b0;

        // A request while any transfer is live, even on its final edge, is dropped undecoded.
        if (iOutReq && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (iOutReq) begin
                    if (iPortAddr == PORT3_ADDR) begin
                        p3_data_d = iData;
                        strobe_d  = 1'b1;
                        tmo_d     = 8'd0;
                        state_d   = P3_WAIT;
                    end else if (iPortAddr == PORT4_ADDR) begin
                        shift_d   = iData;
                        bit_cnt_d = 3'd0;
                        div_d     = 8'd0;
                        serial_d  = 1'b0;
                        active_d  = 1'b1;
                        state_d   = P4_START;
                    end else begin
                        addr_err_d = 1'b1;
                    end
                end
            end

            P3_WAIT: begin
                if (iPort3Ack) begin
                    strobe_d = 1'b0;
                    state_d  = IDLE;
                end else if (tmo_q == TMO_LAST) begin
                    strobe_d  = 1'b0;
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end

            P4_START: begin
                if (div_wrap) begin
                    div_d     = 8'd0;
                    bit_cnt_d = 3'd0;
                    serial_d  = shift_q[0];
                    shift_d   = shift_q >> 1;
                    state_d   = P4_DATA;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end

            P4_DATA: begin
                if (div_wrap) begin
                    div_d = 8'd0;
                    if (bit_cnt_q == 3'd7) begin
                        serial_d = 1'b1;
                        state_d  = P4_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        serial_d  = shift_q[0];
                        shift_d   = shift_q >> 1;
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end

            P4_STOP: begin
                if (div_wrap) begin
                    div_d    = 8'd0;
                    serial_d = 1'b1;
                    active_d = 1'b0;
                    state_d  = IDLE;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge iClk) begin
        // NOTE: non-blocking assignments so every register samples the pre-edge values.
        if (iReset) begin
            state_q    <= IDLE;
            p3_data_q  <= 8'd0;
            strobe_q   <= 1'b0;
            serial_q   <= 1'b1;
            active_q   <= 1'b0;
            busy_q     <= 1'b0;
            shift_q    <= 8'd0;
            bit_cnt_q  <= 3'd0;
            div_q      <= 8'd0;
            tmo_q      <= 8'd0;
            addr_err_q <= 1'b0;
            overrun_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            p3_data_q  <= p3_data_d;
            strobe_q   <= strobe_d;
            serial_q   <= serial_d;
            active_q   <= active_d;
            busy_q     <= busy_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            div_q      <= div_d;
            tmo_q      <= tmo_d;
            addr_err_q <= addr_err_d;
            overrun_q  <= overrun_d;
            timeout_q  <= timeout_d;
        end
    end

    assign oBusy        = busy_q;
    assign oPort3Data   = p3_data_q;
    assign oPort3Strobe = strobe_q;
    assign oPort4Serial = serial_q;
    assign oPort4Active = active_q;
    assign oAddrErr     = addr_err_q;
    assign oOverrun     = overrun_q;
    assign oTimeout     = timeout_q;

endmodule

// File: doc/out_port_ctrl.md
Name: out_port_ctrl

Overview:
- Sequences the SAP-2 output ports for the OUT byte instruction.
- Decodes the port address and drives one of two ports:
  - Port 3: parallel latched byte with strobe/acknowledge handshake to the external device.
  - Port 4: serial shifter sending a framed byte, LSB first.
- Sits between the control sequencer/W-bus and the off-chip pins; oBusy stalls the sequencer until the transfer completes.

Parameters:
- PORT3_ADDR, 8'h03, port address selecting the parallel port
- PORT4_ADDR, 8'h04, port address selecting the serial port
- BIT_DIV, 4, clock cycles per serial bit (legal range 1..255)
- ACK_TIMEOUT, 16, max cycles port 3 waits for iPort3Ack before aborting (legal range 1..255)

Ports:
- iClk  input  1  system clock, all state updates on rising edge
- iReset  input  1  synchronous active-high reset
- iOutReq  input  1  single-cycle OUT request from the sequencer
- iPortAddr  input  8  target port number, sampled with iOutReq
- iData  input  8  byte from the W-bus, sampled with iOutReq
- iPort3Ack  input  1  external acknowledge for port 3
- oBusy  output  1  high while any transfer is in progress
- oPort3Data  output  8  port 3 latched byte
- oPort3Strobe  output  1  port 3 data-valid strobe
- oPort4Serial  output  1  port 4 serial line, idles high
- oPort4Active  output  1  high while a port 4 frame is on the line
- oAddrErr  output  1  one-cycle pulse: request to an unknown port
- oOverrun  output  1  one-cycle pulse: request arrived while busy
- oTimeout  output  1  one-cycle pulse: port 3 acknowledge timed out

Behaviour:
- Reset: iClk and iReset only. iReset is synchronous and active-high, has priority over all events, and aborts any transfer mid-frame. Next edge values:
  - state IDLE
  - oPort3Data = 0, oPort3Strobe = 0
  - oPort4Serial = 1, oPort4Active = 0
  - oBusy = 0, oAddrErr = 0, oOverrun = 0, oTimeout = 0
  - all counters 0
- Registered outputs: all outputs are registered. oBusy = (state != IDLE).
- States: IDLE, P3_WAIT, P4_START, P4_DATA, P4_STOP.
- IDLE, iOutReq = 1 sampled at edge k:
  - iPortAddr == PORT3_ADDR: after edge k, oPort3Data = iData, oPort3Strobe = 1, timeout counter = 0, state P3_WAIT.
  - iPortAddr == PORT4_ADDR: shift register = iData, bit counter = 0, divider = 0, state P4_START, oPort4Serial = 0, oPort4Active = 1.
  - Any other address: oAddrErr = 1 for one cycle, state stays IDLE, no output changes.
- P3_WAIT:
  - iPort3Ack high at any edge → oPort3Strobe = 0, state IDLE.
  - No ack for ACK_TIMEOUT consecutive edges → oPort3Strobe = 0, oTimeout pulses, state IDLE.
  - oPort3Data holds its value after the handshake and after a timeout (latched port). It changes only on a new port 3 request or reset.
  - iPort3Ack is ignored outside P3_WAIT.
- Port 4 frame:
  - One start bit (0), 8 data bits LSB first, one stop bit (1).
  - Each bit is held exactly BIT_DIV cycles, so the frame is 10×BIT_DIV cycles.
  - The divider counts 0..BIT_DIV-1; on wrap it advances bit/state: P4_START→P4_DATA; P4_DATA→P4_STOP after bit 7; P4_STOP→IDLE.
  - Leaving P4_STOP: oPort4Serial stays 1 and oPort4Active = 0.
  - oBusy falls at edge k+10×BIT_DIV for a request at edge k.
- iOutReq while state != IDLE (including the edge on which the transfer completes):
  - Request dropped, oOverrun pulses one cycle.
  - Current transfer unaffected.
  - Address is not decoded, so no oAddrErr.
- Port exclusivity: ports 3 and 4 never transfer simultaneously. oPort3Data is untouched by port 4 activity.
- Pulse flags: oAddrErr, oOverrun and oTimeout are each exactly one cycle wide and low otherwise.

Test Plan:
- Reset with outputs disturbed → oPort3Data = 0, oPort4Serial = 1, oBusy = 0, all flags 0. Assert iReset mid port-4 frame → serial returns to 1 and oBusy = 0 at the next edge.
- OUT 03h, iData = 8'hA5; ack raised 3 cycles later → oPort3Strobe high for 3 cycles, then low. oPort3Data = A5 persists, oBusy low afterward.
- OUT 03h, iData = 8'h3C; no ack (ACK_TIMEOUT = 16) → oTimeout pulses after 16 cycles, strobe drops, oPort3Data = 3C retained.
- OUT 04h, iData = 8'hB2, BIT_DIV = 4 → line reads 0, then 0,1,0,0,1,1,0,1, then 1, each bit 4 cycles. oBusy high exactly 40 cycles.
- Second OUT 04h issued 5 cycles into a frame → oOverrun single pulse, frame bits unchanged. Request on the completion edge is also dropped; request one cycle later is accepted.
- OUT 07h, iData = 8'hFF → oAddrErr one-cycle pulse, oBusy stays 0, all port outputs unchanged.
